// File: rtl/stage_mem.sv
// MEM pipeline stage plus MEM/WB register.
// Drives the data-memory handshake and stalls upstream while busy.
package rv32i_types_pkg;
    typedef struct packed {
        logic       load_regfile;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } rv32i_control_word;
endpackage

module stage_mem
    import rv32i_types_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       alu_out_i,
    input  logic [31:0]       br_en_i,
    input  logic [31:0]       rs2_data_i,
    input  rv32i_control_word cw_i,
    output logic              stall_o,
    output logic [31:0]       dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_mbe,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              wb_valid_o,
    output logic [31:0]       pc_out_o,
    output logic [31:0]       alu_out_o,
    output logic [31:0]       br_en_o,
    output logic [31:0]       mem_rdata_o,
    output rv32i_control_word cw_o,
    output logic              misaligned_o,
    output logic              mem_timeout_o
);
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [31:0]       pc_q;
    logic [31:0]       alu_q;
    logic [31:0]       br_q;
    rv32i_control_word cw_q;

    logic [1:0]  off;
    logic        is_mem;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        accept;
    logic [31:0] wdata_n;
    logic [3:0]  mbe_n;

    assign off        = alu_out_i[1:0];
    assign is_mem     = cw_i.mem_read | cw_i.mem_write;
    assign is_byte    = (cw_i.funct3[1:0] == 2'b00);
    assign is_half    = (cw_i.funct3[1:0] == 2'b01);
    assign is_word    = cw_i.funct3[1];
    assign misaligned = is_mem & ((is_half & (off == 2'b11)) |
                                  (is_word & (off != 2'b00)));
    assign stall_o    = (state == BUSY);
    assign accept     = valid_i & ~flush_i & ~stall_o;

    // Loads use all four lanes; WB extracts the bytes it needs.
    always_comb begin
        wdata_n = '0;
        mbe_n   = 4'b1111;
        if (cw_i.mem_write) begin
            unique case (1'b1)
                is_byte: begin
                    wdata_n = {4{rs2_data_i[7:0]}};
                    mbe_n   = 4'b0001 << off;
                end
                is_half: begin
                    wdata_n = {2{rs2_data_i[15:0]}};
                    mbe_n   = 4'b0011 << off;
                end
                default: wdata_n = rs2_data_i;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            pc_q          <= '0;
            alu_q         <= '0;
            br_q          <= '0;
            cw_q          <= '0;
            dmem_address  <= '0;
            dmem_read     <= 1'b0;
            dmem_write    <= 1'b0;
            dmem_wdata    <= '0;
            dmem_mbe      <= '0;
            wb_valid_o    <= 1'b0;
            pc_out_o      <= '0;
            alu_out_o     <= '0;
            br_en_o       <= '0;
            mem_rdata_o   <= '0;
            cw_o          <= '0;
            misaligned_o  <= 1'b0;
            mem_timeout_o <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && is_mem && !misaligned) begin
                        state        <= BUSY;
                        pc_q         <= pc_i;
                        alu_q        <= alu_out_i;
                        br_q         <= br_en_i;
                        cw_q         <= cw_i;
                        dmem_address <= {alu_out_i[31:2], 2'b00};
                        dmem_write   <= cw_i.mem_write;
                        dmem_read    <= cw_i.mem_read & ~cw_i.mem_write;
                        dmem_wdata   <= wdata_n;
                        dmem_mbe     <= mbe_n;
                    end else if (accept) begin
                        wb_valid_o   <= 1'b1;
                        pc_out_o     <= pc_i;
                        alu_out_o    <= alu_out_i;
                        br_en_o      <= br_en_i;
                        cw_o         <= cw_i;
                        mem_rdata_o  <= '0;
                        misaligned_o <= misaligned;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        wb_valid_o   <= 1'b1;
                        pc_out_o     <= pc_q;
                        alu_out_o    <= alu_q;
                        br_en_o      <= br_q;
                        cw_o         <= cw_q;
                        mem_rdata_o  <= dmem_write ? '0 : dmem_rdata;
                        misaligned_o <= 1'b0;
                        dmem_read    <= 1'b0;
                        dmem_write   <= 1'b0;
                    end else if (WAIT_LIMIT != 0 && cnt != LIM) begin
                        // The access keeps waiting; only the flag is sticky.
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == LIM) mem_timeout_o <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
